// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the MEM stage: funct3 codes and LSU handshake states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

   // Load/store width and sign codes
   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;

   // Conditional branch codes
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // IDLE: no access outstanding; WAIT: a request is waiting for mem_ack
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: alignment, byte enables, store replication, load extend.
// Latency: purely combinational.
// Backpressure: none; outputs simply follow the held stage inputs.
module lsu_align
   import rv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic        is_store,
   input  logic [31:0] rd2,
   input  logic [31:0] rdata,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = rdata[{lane, 3'b000} +: 8];
   assign ld_half = rdata[{lane[1], 4'b0000} +: 16];

   // Natural alignment from the access width held in funct3[1:0]
   always_comb begin
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~lane[0];
         default: aligned = (lane == 2'b00);
      endcase
   end

   // Store byte enables and lane-replicated data; loads always fetch the whole word
   always_comb begin
      be    = 4'b1111;
      wdata = '0;
      if (is_store) begin
         case (funct3)
            F3_B: begin
               be    = 4'b0001 << lane;
               wdata = {4{rd2[7:0]}};
            end
            F3_H: begin
               be    = 4'b0011 << lane;
               wdata = {2{rd2[15:0]}};
            end
            default: wdata = rd2;
         endcase
      end
   end

   // Load extraction and sign/zero extension; unknown codes pass the word through
   always_comb begin
      case (funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {24'b0, ld_byte};
         F3_HU:   ld_data = {16'b0, ld_half};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: branch resolve, req/ack data-memory access with timeout, load align, MEM/WB register.
// Latency: bus signals combinational; MEM/WB updates on the cycle the access completes (ack or timeout).
// Backpressure: stall holds upstream stages while mem_req waits for mem_ack, bounded by TIMEOUT.
module mem_stage_lsu
   import rv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Branch,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic            MemtoReg,
   input  logic            RegWrite,
   input  logic [XLEN-1:0] pc_sum,
   input  logic [XLEN-1:0] ALU,
   input  logic            zero,
   input  logic [XLEN-1:0] rd2,
   input  logic [4:0]      inst3,
   input  logic [2:0]      funct3,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            stall,
   output logic            pcsrc,
   output logic [XLEN-1:0] branch_target,
   output logic            misalign,
   output logic            bus_err,
   output logic            wb_RegWrite,
   output logic            wb_MemtoReg,
   output logic [XLEN-1:0] wb_rdata,
   output logic [XLEN-1:0] wb_alu,
   output logic [4:0]      wb_rd
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t     state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt, cnt_cur;
   logic           is_mem, aligned, misalign_raw, timeout_hit, br_cond;
   logic [XLEN-1:0] ld_data;

   lsu_align u_align (
      .funct3   (funct3),
      .lane     (ALU[1:0]),
      .is_store (MemWrite),
      .rd2      (rd2),
      .rdata    (mem_rdata),
      .aligned  (aligned),
      .be       (mem_be),
      .wdata    (mem_wdata),
      .ld_data  (ld_data)
   );

   assign is_mem       = MemRead | MemWrite;
   assign misalign_raw = is_mem & ~aligned;

   // Strobes are gated by rst_n so an access in flight vanishes the moment reset asserts
   assign mem_req       = is_mem & aligned & rst_n;
   assign mem_we        = MemWrite & mem_req;
   assign mem_addr      = {ALU[XLEN-1:2], 2'b00};
   assign misalign      = misalign_raw & rst_n;
   assign branch_target = pc_sum;
   assign pcsrc         = Branch & br_cond & rst_n;

   // Branch condition: only BEQ/BNE can be taken
   always_comb begin
      case (funct3)
         F3_BEQ:  br_cond = zero;
         F3_BNE:  br_cond = ~zero;
         default: br_cond = 1'b0;
      endcase
   end

   // FSM state and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: enter WAIT on an unacknowledged request, leave on ack, timeout or dropped request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (stall) begin
               state_nxt = WAIT;
               cnt_nxt   = CW'(1);
            end
         end
         WAIT: begin
            if (stall) begin
               cnt_nxt = cnt + CW'(1);
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs: the wait count seen this cycle decides timeout; a same-cycle ack always wins
   always_comb begin
      cnt_cur     = (state == WAIT) ? cnt : '0;
      timeout_hit = mem_req & ~mem_ack & (cnt_cur == CW'(TIMEOUT - 1));
      stall       = mem_req & ~mem_ack & ~timeout_hit;
      bus_err     = timeout_hit;
   end

   // MEM/WB register: bubble while stalled, otherwise retire the instruction leaving MEM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_RegWrite <= 1'b0;
         wb_MemtoReg <= 1'b0;
         wb_rdata    <= '0;
         wb_alu      <= '0;
         wb_rd       <= '0;
      end else if (stall) begin
         wb_RegWrite <= 1'b0;
         wb_MemtoReg <= 1'b0;
      end else begin
         wb_RegWrite <= RegWrite & ~misalign_raw & ~timeout_hit;
         wb_MemtoReg <= MemtoReg;
         wb_rdata    <= ld_data;
         wb_alu      <= ALU;
         wb_rd       <= inst3;
      end
   end

endmodule
